// File: rtl/interpon.sv
// Linear interpolator: turns a strobed low-rate 17-bit sample stream into a clk-rate ramp
// using a serial shift-add multiplier, so no run-time divider is needed.
module interpon #(
  parameter int PERIOD = 20,
  parameter int FRAC   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [16:0] y_in,
  input  logic               strobe,
  output logic signed [17:0] y_out
);

  localparam int PW = 18 + FRAC;
  // Reciprocal of the strobe spacing, rounded to nearest, folded at elaboration.
  localparam longint R_FULL = ((64'sd1 <<< FRAC) + 64'(PERIOD / 2)) / 64'(PERIOD);
  localparam logic [FRAC-1:0] R    = R_FULL[FRAC-1:0];
  localparam logic [3:0]      LAST = 4'(FRAC - 1);

  logic signed [16:0]   y_hold, y_prev;
  logic signed [17:0]   dy, dy_new;
  logic signed [PW-1:0] dy_ext, mcand, prod, step, accum;
  logic [3:0]           mcount;
  logic                 mfin, mdone0, mdone1, check1;
  logic                 start;

  // A strobe only lands when the multiplier is idle; otherwise it is dropped untouched.
  assign start  = strobe && (mcount == 4'd0);
  assign dy_new = {y_in[16], y_in} - {y_hold[16], y_hold};
  assign dy_ext = PW'(dy_new);

  // Sample capture and serial multiply. Bit 0 of R is consumed on the strobe edge itself,
  // bits 1..FRAC-1 on the following edges, so mcount fits in four bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_hold <= '0;
      y_prev <= '0;
      dy     <= '0;
      prod   <= '0;
      mcand  <= '0;
      mcount <= '0;
      mfin   <= 1'b0;
      mdone0 <= 1'b0;
      mdone1 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let the load path below see the pre-strobe y_prev and
      // product when a strobe and a load share an edge.
      if (start) begin
        y_prev <= y_hold;
        y_hold <= y_in;
        dy     <= dy_new;
        prod   <= R[0] ? dy_ext : '0;
        mcand  <= dy_ext <<< 1;
        mcount <= 4'd1;
      end else if (mcount != 4'd0) begin
        if (R[mcount]) prod <= prod + mcand;
        mcand  <= mcand <<< 1;
        mcount <= (mcount == LAST) ? 4'd0 : mcount + 4'd1;
      end
      mfin   <= (mcount == LAST);
      mdone0 <= mfin;
      mdone1 <= mdone0;
    end
  end

  // Ramp accumulator: reload from the previous sample when the product is ready, else step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accum  <= '0;
      step   <= '0;
      check1 <= 1'b0;
    end else begin
      if (mdone1) begin
        accum <= {y_prev[16], y_prev, {FRAC{1'b0}}};
        step  <= prod;
      end else begin
        accum <= accum + step;
      end
      check1 <= mdone1;
    end
  end

  assign y_out = accum[FRAC+17:FRAC];

endmodule

// File: tb/tb_interpon.sv
// Scoreboard bench for interpon: each accepted strobe queues the expected ramp segment, and a
// monitor triggered by the load pulse checks load timing and every ramp value.
module tb_interpon;

  localparam int  PERIOD = 20;
  localparam longint R_TB = 3277;  // round(65536 / 20) = round(3276.8)

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic signed [16:0] y_in = '0;
  logic               strobe = 1'b0;
  logic signed [17:0] y_out;

  interpon #(.PERIOD(PERIOD), .FRAC(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .y_in   (y_in),
    .strobe (strobe),
    .y_out  (y_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     start;
    longint dyr;
    int     load_edge;
  } item_t;

  item_t sb[$];
  int    hold_m = 0;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint ramp_val(input int start, input longint dyr, input int k);
    longint v;
    logic signed [17:0] r;
    v = (longint'(start) <<< 16) + longint'(k) * dyr;
    r = 18'(v >>> 16);
    return longint'(r);
  endfunction

  // Accepted strobe: push expected segment, hold strobe one cycle, then idle to make `gap`.
  task automatic send(input int y, input int gap, input bit chk_zero);
    item_t it;
    y_in   = 17'(y);
    strobe = 1'b1;
    it.start     = hold_m;
    it.dyr       = longint'(y - hold_m) * R_TB;
    it.load_edge = cyc + 1 + 18;
    sb.push_back(it);
    hold_m = y;
    for (int i = 1; i <= gap; i++) begin
      @(negedge clk);
      if (i == 1) strobe = 1'b0;
      if (chk_zero && i <= 18) check("zero_after_reset_strobe", longint'(y_out), 0);
    end
  endtask

  task automatic send_ignored(input int y, input int gap);
    y_in   = 17'(y);
    strobe = 1'b1;
    for (int i = 1; i <= gap; i++) begin
      @(negedge clk);
      if (i == 1) strobe = 1'b0;
    end
  endtask

  task automatic idle_zero(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_zero", longint'(y_out), 0);
    end
  endtask

  // Monitor: every load pulse pops one segment and checks its full ramp.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (rst_n && dut.check1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_load: got load at cycle %0d expected none", cyc);
        end else begin
          it = sb.pop_front();
          check("load_time", longint'(cyc), longint'(it.load_edge));
          for (int k = 0; k < PERIOD; k++) begin
            if (k > 0) @(negedge clk);
            if (!rst_n) break;
            check(k == 0 ? "load_value" : "ramp_value", longint'(y_out),
                  ramp_val(it.start, it.dyr, k));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic signed [16:0] r;
    #2 rst_n = 1'b0;
    #1 check("reset_async", longint'(y_out), 0);

    // Reset held with strobe toggling.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      strobe = ~strobe;
      y_in   = 17'(1234 + i);
      check("reset_hold", longint'(y_out), 0);
    end
    @(negedge clk);
    strobe = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);

    // Constant 1000: first segment ramps from 0, then flat at 1000.
    send(1000, PERIOD, 1'b1);
    for (int i = 0; i < 3; i++) send(1000, PERIOD, 1'b0);

    // Ramp 0 -> 2000 -> 2000: rises 100 per cycle.
    send(0, PERIOD, 1'b0);
    send(2000, PERIOD, 1'b0);
    send(2000, PERIOD, 1'b0);

    // Extreme swing, dy = 131071.
    send(-65536, PERIOD, 1'b0);
    send(65535, PERIOD, 1'b0);
    send(65535, PERIOD, 1'b0);

    // Busy strobe 5 cycles after an accepted one must be dropped.
    send(300, 5, 1'b0);
    send_ignored(-300, PERIOD - 5);
    send(300, PERIOD, 1'b0);

    // Reset in the middle of a ramp.
    send(-20000, 25, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    hold_m = 0;
    #1 check("reset_mid_ramp", longint'(y_out), 0);
    idle_zero(3);
    rst_n = 1'b1;
    idle_zero(30);

    // Reset in the middle of a multiply: no stale load afterwards.
    y_in   = 17'(500);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    idle_zero(3);
    rst_n = 1'b1;
    idle_zero(40);

    // Random samples at nominal spacing.
    for (int i = 0; i < 1500; i++) begin
      r = 17'($urandom);
      send(int'(r), PERIOD, 1'b0);
    end

    repeat (PERIOD + 25) @(negedge clk);
    check("scoreboard_empty", longint'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/interpon.md
INTERPON -- requirements
Module: interpon

Interface
REQ-001 Parameter PERIOD, default 20: strobe spacing in clk cycles; legal range 19..4096.
REQ-002 Parameter FRAC, default 16: fraction bits of the interpolation accumulator.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 y_in  input  17: signed two's-complement low-rate sample, valid in a strobe cycle.
REQ-006 strobe  input  1: one-cycle pulse marking a new y_in sample, nominally every PERIOD cycles.
REQ-007 y_out  output  18: signed interpolated sample at clk rate, sign-extended (y_out[17]==y_out[16] for legal input).

Function
REQ-008 The block SHALL hold constant R = round(2^FRAC / PERIOD), an unsigned FRAC-bit value computed at elaboration.
REQ-009 On a strobe edge (cycle t), the block SHALL do all of the following on that same edge:
- y_prev <= y_hold
- y_hold <= y_in
- dy <= y_in - y_hold, computed as an 18-bit signed value (exact, no overflow)
- start the multiplier
REQ-010 The multiplier SHALL be a serial shift-add of dy by R, one bit of R per cycle over FRAC cycles.
- 4-bit counter mcount is nonzero while the multiply is busy.
- Result step = dy*R, (18+FRAC)-bit signed, exact.
REQ-011 mdone1 SHALL pulse for one cycle at edge t+17; the product is final at that point.
REQ-012 At edge t+18, the block SHALL:
- load accum <= y_prev << FRAC, with zero fraction;
- latch step as the per-cycle increment.
REQ-013 On every edge other than a load edge, accum SHALL update accum <= accum + step.
- accum is 18+FRAC bits signed and wraps two's-complement.
REQ-014 y_out SHALL equal accum[FRAC+17:FRAC], the integer part truncated toward minus infinity.
REQ-015 Latency: from edge t+18, y_out[16:0] SHALL equal the sample captured at the previous strobe, exactly.
REQ-016 Ramp:
- y_out moves linearly from that previous sample toward the sample captured at t.
- After k increments, y_out = floor(y_prev + k*dy*R/2^FRAC).
- The next load lands within 1 LSB plus PERIOD*|rounding of R| of the continued ramp.
REQ-017 Internal flag check1 SHALL pulse on the cycle after each load edge; at that moment y_out[16:0] == y_prev exactly.
REQ-018 Strobe timing rules:
- A strobe arriving while mcount is nonzero SHALL be ignored, with no register change.
- Strobe spacing below PERIOD is otherwise a usage error.
REQ-019 If no further strobe arrives, accum SHALL keep incrementing by the last step indefinitely, wrapping as in REQ-013.
REQ-020 A strobe and a load SHALL be able to coincide on the same edge; each acts independently per REQ-009 and REQ-012.
REQ-021 The design SHALL be fully synchronous apart from rst_n and SHALL use no divider at run time.

Reset
REQ-022 While rst_n is low, the following SHALL be 0: y_hold, y_prev, dy, step, accum, mcount, mdone1, check1 and y_out.
REQ-023 Reset deassertion SHALL take effect on the next rising edge, and the block SHALL resume waiting for a strobe.
REQ-024 Reset asserted mid-multiply or mid-ramp SHALL abort the operation immediately.
- No stale load SHALL occur after release.

Verification
REQ-025 Reset: hold rst_n low 5 cycles with strobe toggling -> y_out = 0 throughout and for 18 edges after the first post-reset strobe.
REQ-026 Constant input: y_in = 1000 on every strobe, PERIOD = 20 -> y_out = 1000 constant from the second segment onward, step = 0.
REQ-027 Ramp: samples 0 then 2000 then 2000, PERIOD = 20.
- At edge t2+18, y_out = 0.
- y_out then rises 100 per cycle, values 0, 100, ..., 1900.
- At edge t3+18, y_out = 2000.
REQ-028 Negative and extreme swing: samples -65536 then 65535.
- dy = 131071 with no overflow.
- y_out ramps from -65536 upward, and y_out[17] tracks the sign.
REQ-029 Random 17-bit samples, strobe every PERIOD cycles, for 30000 cycles -> at every strobe+18, y_out[16:0] equals the sample of the preceding strobe, and check1 never reports a mismatch.
REQ-030 Busy strobe: a second strobe 5 cycles after the first -> ignored; y_hold unchanged; load still at first strobe +18.
